divisible_by_n_stream: RTL and testbench
========================================

Name: divisible_by_n_stream

Overview:
- Parametrised successor to the serial divisible-by-5 FSM.
- Checks a serially streamed unsigned number against a runtime-programmable divisor D (1..2^DIV_W-1).
- Consumes IN_W bits per accepted beat, MSB-first or LSB-first.
- Reports the running remainder and a divisibility flag each cycle.
- Sits on a bit/nibble stream beside the serial-protocol blocks, as a reusable mod-N checker.

Parameters:
- DIV_W, 8, width of divisor and remainder.
- IN_W, 1, data bits consumed per accepted beat (1..8).
- CNT_W, 16, width of the beat counter (saturating).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; latches div_in and lsb_first, clears remainder/count.
- div_in  input  DIV_W  divisor, sampled only on start.
- lsb_first  input  1  mode, sampled only on start; 0 = MSB-first, 1 = LSB-first.
- in_valid  input  1  beat qualifier for in_data.
- in_data  input  IN_W  next digit; in MSB-first mode the digit MSB is most significant.
- rem_out  output  DIV_W  current value mod D.
- out  output  1  1 when running and rem_out == 0.
- running  output  1  1 in RUN state.
- err_div0  output  1  1 in ERR state (start issued with div_in == 0).
- beat_count  output  CNT_W  accepted beats since start; saturates at all-ones.

Behaviour:
- Reset (async, active-high):
  - State IDLE; rem, weight, beat_count = 0.
  - out = 0, running = 0, err_div0 = 0.
- States: IDLE, RUN, ERR.
- Any state, start with div_in != 0:
  - Go to RUN; D <= div_in; mode <= lsb_first.
  - rem <= 0, beat_count <= 0, weight <= 1 mod D (0 when D == 1, else 1).
- Any state, start with div_in == 0: go to ERR; rem <= 0.
- start has priority over in_valid in the same cycle; that beat is dropped and not counted.
- IDLE / ERR: in_valid is ignored. Only start or reset leaves these states.
- RUN, in_valid = 0: all state holds.
- RUN, in_valid = 1, MSB-first: rem <= (rem*2^IN_W + in_data) mod D.
  - Computed as IN_W restoring steps, MSB of in_data first.
  - Each step: r = 2r + bit; if r >= D then r -= D.
  - Intermediate width DIV_W+1; no division operator.
- RUN, in_valid = 1, LSB-first: rem <= (rem + in_data*weight) mod D, and weight <= (weight*2^IN_W) mod D.
  - Product mod D computed by IN_W Horner steps over in_data bits (double mod D, conditional add-weight mod D).
  - weight update uses IN_W conditional doublings.
- beat_count increments per accepted beat and saturates at all-ones.
- Latency: outputs are registered and reflect a beat one edge after it is accepted.
- out is combinational from registered state: (state == RUN) && (rem == 0).
  - Immediately after start, out = 1 (empty number = 0 is divisible).
- rem_out is held at 0 outside RUN.
- D == 1: rem stays 0; out stays 1 in RUN.
- Reset mid-run: immediate return to IDLE, outputs to reset values, no partial update.
- Mode and divisor are never changed mid-stream except via start.

Decomposition:
- Shared package:
  - State enum (IDLE, RUN, ERR).
  - Localparam for weight reset value.
  - Function mod_double_add(r, bit, D) returning (2r+bit) mod D, used by both modes.
- One natural sub-module: mod_n_step.
  - Combinational chain of IN_W conditional-subtract stages.
  - Instantiated twice: remainder path and weight path.

Test Plan:
- Reset then start D=5, MSB-first, IN_W=1; bits 1,0,1,0 -> rem_out 1,2,0,0; out 0,0,1,1; beat_count 4.
- Start D=3, LSB-first, IN_W=1; bits 1,1 (value 3) -> rem_out 1 then 0; out 0 then 1.
- IN_W=4 build, start D=7, MSB-first; nibbles 0x3, 0x8 (0x38 = 56) -> rem_out 3 then 0; out 1 after the second beat.
- start with div_in=0 -> err_div0=1, running=0, out=0; subsequent in_valid beats leave rem_out=0 and beat_count=0; a start with D=5 clears err_div0.
- Mid-stream, D=5 after bits 1,1 (rem 3):
  - Gap of 3 cycles with in_valid=0 -> rem_out holds at 3.
  - start with in_valid=1 in the same cycle -> rem 0, beat_count 0, beat dropped.
- Reset asserted asynchronously mid-run (between edges) -> outputs 0 immediately; running=0; after release, in_valid is ignored until start.

Source files
------------

// File: rtl/divisible_by_n_stream_pkg.sv
// Shared types and modular helpers for the streaming mod-N checker.
// Arithmetic is done at a fixed wide width so every caller can share it.
package divisible_by_n_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } state_t;

  localparam int unsigned MW = 32;
  localparam logic [MW-1:0] WEIGHT_ONE = 1;

  // Operands are already reduced (r < d), so one subtract suffices.
  function automatic logic [MW-1:0] mod_double_add(
    input logic [MW-1:0] r,
    input logic          b,
    input logic [MW-1:0] d
  );
    logic [MW-1:0] t;
    t = {r[MW-2:0], b};
    if (t >= d) t = t - d;
    return t;
  endfunction

  function automatic logic [MW-1:0] mod_add(
    input logic [MW-1:0] a,
    input logic [MW-1:0] b,
    input logic [MW-1:0] d
  );
    logic [MW-1:0] t;
    t = a + b;
    if (t >= d) t = t - d;
    return t;
  endfunction

endpackage

// File: rtl/divisible_by_n_stream_step.sv
// Horner chain: seed*2^IN_W + digit*addend, reduced mod d,
// one conditional-subtract stage per digit bit, MSB first.
module mod_n_step
  import divisible_by_n_stream_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int IN_W  = 1
) (
  input  logic [DIV_W-1:0] d,
  input  logic [DIV_W-1:0] seed,
  input  logic [DIV_W-1:0] addend,
  input  logic [IN_W-1:0]  digit,
  output logic [DIV_W-1:0] result
);

  logic [MW-1:0] acc;

  always_comb begin
    acc = MW'(seed);
    for (int i = IN_W - 1; i >= 0; i--) begin
      acc = mod_double_add(acc, 1'b0, MW'(d));
      if (digit[i]) acc = mod_add(acc, MW'(addend), MW'(d));
    end
    result = DIV_W'(acc);
  end

endmodule

// File: rtl/divisible_by_n_stream.sv
// Serial mod-N checker: consumes IN_W-bit digits MSB- or LSB-first
// and tracks value mod a divisor latched on start.
module divisible_by_n_stream
  import divisible_by_n_stream_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int IN_W  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] div_in,
  input  logic             lsb_first,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic [DIV_W-1:0] rem_out,
  output logic             out,
  output logic             running,
  output logic             err_div0,
  output logic [CNT_W-1:0] beat_count
);

  state_t           state;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] weight;
  logic             mode;
  logic [DIV_W-1:0] one_d;
  logic [DIV_W-1:0] step_seed;
  logic [DIV_W-1:0] step_add;
  logic [DIV_W-1:0] rem_step;
  logic [DIV_W-1:0] wt_step;
  logic [DIV_W-1:0] rem_nxt;

  assign one_d = (d == DIV_W'(1)) ? '0 : DIV_W'(WEIGHT_ONE);

  // LSB-first: chain yields digit*weight; MSB-first: rem*2^IN_W+digit.
  assign step_seed = mode ? '0 : rem;
  assign step_add  = mode ? weight : one_d;

  mod_n_step #(.DIV_W(DIV_W), .IN_W(IN_W)) u_rem (
    .d      (d),
    .seed   (step_seed),
    .addend (step_add),
    .digit  (in_data),
    .result (rem_step)
  );

  mod_n_step #(.DIV_W(DIV_W), .IN_W(IN_W)) u_wt (
    .d      (d),
    .seed   (weight),
    .addend ('0),
    .digit  ('0),
    .result (wt_step)
  );

  assign rem_nxt = mode
    ? DIV_W'(mod_add(MW'(rem), MW'(rem_step), MW'(d)))
    : rem_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      d          <= '0;
      mode       <= 1'b0;
      rem        <= '0;
      weight     <= '0;
      beat_count <= '0;
    end else if (start) begin
      rem        <= '0;
      beat_count <= '0;
      if (div_in != '0) begin
        state  <= RUN;
        d      <= div_in;
        mode   <= lsb_first;
        weight <= (div_in == DIV_W'(1)) ? '0 : DIV_W'(WEIGHT_ONE);
      end else begin
        state <= ERR;
      end
    end else if (state == RUN && in_valid) begin
      rem <= rem_nxt;
      if (mode) weight <= wt_step;
      if (beat_count != '1) beat_count <= beat_count + 1'b1;
    end
  end

  assign running  = (state == RUN);
  assign err_div0 = (state == ERR);
  assign rem_out  = running ? rem : '0;
  assign out      = running && (rem == '0);

endmodule

// File: tb/tb_divisible_by_n_stream.sv
// Scoreboard bench for the mod-N stream checker,
// one DUT with 1-bit digits and one with nibble digits.
module tb_divisible_by_n_stream;

  typedef struct {
    int d; bit lsb; int rem; int w; int cnt; bit run; bit err;
  } mdl_t;

  typedef struct {
    int rem; bit out; int cnt; bit run; bit err;
  } exp_t;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic        s1 = 0, l1 = 0, v1 = 0;
  logic [7:0]  dv1 = 0;
  logic [0:0]  x1 = 0;
  logic [7:0]  r1;
  logic        o1, ru1, e1;
  logic [15:0] c1;

  logic        s4 = 0, l4 = 0, v4 = 0;
  logic [7:0]  dv4 = 0;
  logic [3:0]  x4 = 0;
  logic [7:0]  r4;
  logic        o4, ru4, e4;
  logic [15:0] c4;

  divisible_by_n_stream #(.DIV_W(8), .IN_W(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .div_in(dv1),
    .lsb_first(l1), .in_valid(v1), .in_data(x1),
    .rem_out(r1), .out(o1), .running(ru1), .err_div0(e1),
    .beat_count(c1)
  );

  divisible_by_n_stream #(.DIV_W(8), .IN_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .reset(reset), .start(s4), .div_in(dv4),
    .lsb_first(l4), .in_valid(v4), .in_data(x4),
    .rem_out(r4), .out(o4), .running(ru4), .err_div0(e4),
    .beat_count(c4)
  );

  mdl_t m1, m4;
  exp_t q1[$], q4[$];
  int total = 0;
  int bad = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m = '{d: 0, lsb: 0, rem: 0, w: 0, cnt: 0, run: 0, err: 0};
    return m;
  endfunction

  function automatic mdl_t mstart(mdl_t m, int d, bit lsb);
    m.cnt = 0;
    m.rem = 0;
    if (d != 0) begin
      m.run = 1; m.err = 0; m.d = d; m.lsb = lsb; m.w = 1 % d;
    end else begin
      m.run = 0; m.err = 1;
    end
    return m;
  endfunction

  function automatic mdl_t mbeat(mdl_t m, int x, int inw);
    if (!m.run) return m;
    if (m.lsb) begin
      m.rem = (m.rem + x * m.w) % m.d;
      m.w = (m.w * (1 << inw)) % m.d;
    end else begin
      m.rem = (m.rem * (1 << inw) + x) % m.d;
    end
    if (m.cnt < 65535) m.cnt++;
    return m;
  endfunction

  function automatic exp_t mexp(mdl_t m);
    exp_t e;
    e.rem = m.run ? m.rem : 0;
    e.out = m.run && (m.rem == 0);
    e.cnt = m.cnt;
    e.run = m.run;
    e.err = m.err;
    return e;
  endfunction

  task automatic start1(int d, bit lsb, bit v = 0, int x = 0);
    s1 = 1; dv1 = 8'(d); l1 = lsb; v1 = v; x1 = 1'(x);
    m1 = mstart(m1, d, lsb);
    q1.push_back(mexp(m1));
    @(posedge clk); #1;
    s1 = 0; v1 = 0;
  endtask

  task automatic beat1(int x, bit v = 1);
    v1 = v; x1 = 1'(x);
    if (v) m1 = mbeat(m1, x, 1);
    q1.push_back(mexp(m1));
    @(posedge clk); #1;
    v1 = 0;
  endtask

  task automatic start4(int d, bit lsb);
    s4 = 1; dv4 = 8'(d); l4 = lsb; v4 = 0;
    m4 = mstart(m4, d, lsb);
    q4.push_back(mexp(m4));
    @(posedge clk); #1;
    s4 = 0;
  endtask

  task automatic beat4(int x, bit v = 1);
    v4 = v; x4 = 4'(x);
    if (v) m4 = mbeat(m4, x, 4);
    q4.push_back(mexp(m4));
    @(posedge clk); #1;
    v4 = 0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({r1, o1, ru1, e1, c1} !== 27'd0) begin
      bad++;
      $display("FAIL reset_dut1: got rem=%0d out=%b run=%b err=%b cnt=%0d want all 0",
               r1, o1, ru1, e1, c1);
    end
    total++;
    if ({r4, o4, ru4, e4, c4} !== 27'd0) begin
      bad++;
      $display("FAIL reset_dut4: got rem=%0d out=%b run=%b err=%b cnt=%0d want all 0",
               r4, o4, ru4, e4, c4);
    end
    reset = 0;
    m1 = mreset();
    m4 = mreset();
    @(posedge clk); #1;
  endtask

  task automatic test_msb_d5();
    int xs[5] = '{0, 1, 0, 1, 0};
    int er[5] = '{0, 1, 2, 0, 0};
    bit eo[5] = '{1, 0, 0, 1, 1};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) start1(5, 0);
      else beat1(xs[i]);
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || o1 !== e.out || c1 !== 16'(e.cnt) ||
          ru1 !== e.run || e1 !== e.err) begin
        bad++;
        $display("FAIL msb_d5 step %0d: got rem=%0d out=%b cnt=%0d run=%b err=%b want rem=%0d out=%b cnt=%0d run=%b err=%b",
                 i, r1, o1, c1, ru1, e1, e.rem, e.out, e.cnt, e.run, e.err);
      end
      total++;
      if (r1 !== 8'(er[i]) || o1 !== eo[i]) begin
        bad++;
        $display("FAIL msb_d5_table step %0d: got rem=%0d out=%b want rem=%0d out=%b",
                 i, r1, o1, er[i], eo[i]);
      end
    end
    total++;
    if (c1 !== 16'd4) begin
      bad++;
      $display("FAIL msb_d5_count: got %0d want 4", c1);
    end
  endtask

  task automatic test_lsb_d3();
    int er[3] = '{0, 1, 0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) start1(3, 1);
      else beat1(1);
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || o1 !== e.out || c1 !== 16'(e.cnt) ||
          r1 !== 8'(er[i])) begin
        bad++;
        $display("FAIL lsb_d3 step %0d: got rem=%0d out=%b cnt=%0d want rem=%0d out=%b cnt=%0d",
                 i, r1, o1, c1, e.rem, e.out, e.cnt);
      end
    end
  endtask

  task automatic test_nibble();
    int ds[2] = '{7, 11};
    bit ls[2] = '{0, 1};
    int xs[2][2] = '{'{3, 8}, '{8, 3}};
    int er[2][3] = '{'{0, 3, 0}, '{0, 8, 1}};
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        if (i == 0) start4(ds[r], ls[r]);
        else beat4(xs[r][i-1]);
        e = q4.pop_front();
        total++;
        if (r4 !== 8'(e.rem) || o4 !== e.out || c4 !== 16'(e.cnt) ||
            ru4 !== e.run || r4 !== 8'(er[r][i])) begin
          bad++;
          $display("FAIL nibble run %0d step %0d: got rem=%0d out=%b cnt=%0d want rem=%0d out=%b cnt=%0d",
                   r, i, r4, o4, c4, e.rem, e.out, e.cnt);
        end
      end
    end
  endtask

  task automatic test_div0();
    bit ks[5] = '{0, 1, 1, 1, 0};
    int ds[5] = '{0, 0, 0, 0, 5};
    bit ee[5] = '{1, 1, 1, 1, 0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (ks[i] == 0) start1(ds[i], 0);
      else beat1(1);
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || o1 !== e.out || c1 !== 16'(e.cnt) ||
          ru1 !== e.run || e1 !== e.err || e1 !== ee[i]) begin
        bad++;
        $display("FAIL div0 step %0d: got rem=%0d out=%b cnt=%0d run=%b err=%b want rem=%0d out=%b cnt=%0d run=%b err=%b",
                 i, r1, o1, c1, ru1, e1, e.rem, e.out, e.cnt, e.run, e.err);
      end
    end
  endtask

  task automatic test_gap();
    int er[7] = '{0, 1, 3, 3, 3, 3, 0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) start1(5, 0);
      else if (i < 3) beat1(1);
      else if (i < 6) beat1(1, 0);
      else start1(5, 0, 1, 1);
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || o1 !== e.out || c1 !== 16'(e.cnt) ||
          r1 !== 8'(er[i])) begin
        bad++;
        $display("FAIL gap step %0d: got rem=%0d out=%b cnt=%0d want rem=%0d out=%b cnt=%0d",
                 i, r1, o1, c1, e.rem, e.out, e.cnt);
      end
    end
  endtask

  task automatic test_d1();
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) start1(1, 0);
      else if (i == 7) start1(1, 1);
      else beat1(int'($urandom_range(1, 0)));
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || o1 !== e.out || c1 !== 16'(e.cnt) ||
          o1 !== 1'b1) begin
        bad++;
        $display("FAIL d1 step %0d: got rem=%0d out=%b cnt=%0d want rem=%0d out=%b cnt=%0d",
                 i, r1, o1, c1, e.rem, e.out, e.cnt);
      end
    end
  endtask

  task automatic test_random();
    int d;
    bit lsb;
    exp_t e;
    for (int r = 0; r < 6; r++) begin
      d = (r == 0) ? 255 : int'($urandom_range(255, 2));
      lsb = r[0];
      for (int i = 0; i < 21; i++) begin
        if (i == 0) start4(d, lsb);
        else beat4(int'($urandom_range(15, 0)), 1'($urandom_range(3, 0) != 0));
        e = q4.pop_front();
        total++;
        if (r4 !== 8'(e.rem) || o4 !== e.out || c4 !== 16'(e.cnt) ||
            ru4 !== e.run || e4 !== e.err) begin
          bad++;
          $display("FAIL random d=%0d lsb=%b step %0d: got rem=%0d out=%b cnt=%0d want rem=%0d out=%b cnt=%0d",
                   d, lsb, i, r4, o4, c4, e.rem, e.out, e.cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    start1(5, 0);
    beat1(1);
    beat1(1);
    q1.delete();
    total++;
    if (r1 !== 8'd3) begin
      bad++;
      $display("FAIL areset_pre: got rem=%0d want 3", r1);
    end
    #2 reset = 1;
    #1;
    total++;
    if ({r1, o1, ru1, e1, c1} !== 27'd0 || {r4, ru4, c4} !== 25'd0) begin
      bad++;
      $display("FAIL areset_mid: got rem=%0d out=%b run=%b cnt=%0d want all 0",
               r1, o1, ru1, c1);
    end
    @(negedge clk);
    reset = 0;
    m1 = mreset();
    m4 = mreset();
    #1;
    for (int i = 0; i < 3; i++) begin
      beat1(1);
      e = q1.pop_front();
      total++;
      if (r1 !== 8'(e.rem) || ru1 !== e.run || c1 !== 16'(e.cnt) ||
          o1 !== e.out || ru1 !== 1'b0) begin
        bad++;
        $display("FAIL areset_after step %0d: got rem=%0d run=%b cnt=%0d want rem=%0d run=%b cnt=%0d",
                 i, r1, ru1, c1, e.rem, e.run, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_d5();
    test_lsb_d3();
    test_nibble();
    test_div0();
    test_gap();
    test_d1();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
